// File: rtl/matmul_stream_bridge.sv
// Host-side bridge for the 4x4 systolic matrix multiplier. Collects A and B from a byte stream,
// strobes the multiplier, captures C on its result pulse and streams C back as 16-bit words.
module matmul_stream_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                   i_clk,
  input  logic                   i_arst,
  input  logic [7:0]             i_inData,
  input  logic                   i_inValid,
  output logic                   o_inReady,
  output logic [3:0][3:0][7:0]   o_a,
  output logic [3:0][3:0][7:0]   o_b,
  output logic                   o_validInput,
  input  logic [3:0][3:0][15:0]  i_c,
  input  logic                   i_validResult,
  output logic [15:0]            o_outData,
  output logic                   o_outValid,
  input  logic                   i_outReady,
  output logic                   o_busy,
  output logic                   o_timeoutErr
);

  localparam logic [1:0] StLoad  = 2'd0;
  localparam logic [1:0] StStart = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StDrain = 2'd3;

  // Timer value on the last WAIT cycle before giving up.
  localparam logic [3:0] TimerLast = 4'(TIMEOUT_CYCLES - 1);

  logic [1:0]             state_q, state_d;
  logic [4:0]             load_idx_q, load_idx_d;
  logic [3:0]             drain_idx_q, drain_idx_d;
  logic [3:0]             timer_q, timer_d;
  logic [3:0][3:0][7:0]   a_q, a_d;
  logic [3:0][3:0][7:0]   b_q, b_d;
  logic [3:0][3:0][15:0]  c_q, c_d;
  logic                   timeout_err_q, timeout_err_d;

  // Next-state logic for the load / start / wait / drain sequence.
  always_comb begin
    state_d       = state_q;
    load_idx_d    = load_idx_q;
    drain_idx_d   = drain_idx_q;
    timer_d       = timer_q;
    a_d           = a_q;
    b_d           = b_q;
    c_d           = c_q;
    timeout_err_d = 1'b0;
    case (state_q)
      StLoad: begin
        if (i_inValid) begin
          // Bit 4 of the index selects B; the low nibble is row-major within the matrix.
          if (!load_idx_q[4]) begin
            a_d[load_idx_q[3:2]][load_idx_q[1:0]] = i_inData;
          end else begin
            b_d[load_idx_q[3:2]][load_idx_q[1:0]] = i_inData;
          end
          if (load_idx_q == 5'd31) begin
            load_idx_d = 5'd0;
            state_d    = StStart;
          end else begin
            load_idx_d = load_idx_q + 5'd1;
          end
        end
      end
      StStart: begin
        timer_d = 4'd0;
        state_d = StWait;
      end
      StWait: begin
        // A result on the expiry cycle still wins over the timeout.
        if (i_validResult) begin
          c_d     = i_c;
          timer_d = 4'd0;
          state_d = StDrain;
        end else if (timer_q == TimerLast) begin
          timeout_err_d = 1'b1;
          timer_d       = 4'd0;
          state_d       = StLoad;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      StDrain: begin
        if (i_outReady) begin
          if (drain_idx_q == 4'd15) begin
            drain_idx_d = 4'd0;
            state_d     = StLoad;
          end else begin
            drain_idx_d = drain_idx_q + 4'd1;
          end
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // State and datapath registers; reset discards any partial load or undrained result.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q       <= StLoad;
      load_idx_q    <= '0;
      drain_idx_q   <= '0;
      timer_q       <= '0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_idx_q    <= load_idx_d;
      drain_idx_q   <= drain_idx_d;
      timer_q       <= timer_d;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Outputs come only from registers or decoded state, never straight from inputs.
  always_comb begin
    o_inReady    = (state_q == StLoad);
    o_validInput = (state_q == StStart);
    o_outValid   = (state_q == StDrain);
    o_busy       = (state_q != StLoad);
    o_timeoutErr = timeout_err_q;
    o_a          = a_q;
    o_b          = b_q;
    o_outData    = c_q[drain_idx_q[3:2]][drain_idx_q[1:0]];
  end

endmodule

// File: tb/tb_matmul_stream_bridge.sv
// Bench for matmul_stream_bridge: a behavioural multiplier answers the start strobe, and a
// scoreboard queue holds the C words expected from each loaded operation.
module tb_matmul_stream_bridge;

  localparam int TO = 15;

  logic                  i_clk = 1'b0;
  logic                  i_arst = 1'b1;
  logic [7:0]            i_inData = '0;
  logic                  i_inValid = 1'b0;
  logic                  o_inReady;
  logic [3:0][3:0][7:0]  o_a, o_b;
  logic                  o_validInput;
  logic [3:0][3:0][15:0] i_c;
  logic                  i_validResult;
  logic [15:0]           o_outData;
  logic                  o_outValid;
  logic                  i_outReady = 1'b0;
  logic                  o_busy;
  logic                  o_timeoutErr;

  matmul_stream_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_arst(i_arst), .i_inData(i_inData), .i_inValid(i_inValid),
    .o_inReady(o_inReady), .o_a(o_a), .o_b(o_b), .o_validInput(o_validInput),
    .i_c(i_c), .i_validResult(i_validResult), .o_outData(o_outData),
    .o_outValid(o_outValid), .i_outReady(i_outReady), .o_busy(o_busy),
    .o_timeoutErr(o_timeoutErr)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] exp_q[$];

  // Behavioural multiplier controls.
  bit                    mdl_en = 1'b1;
  int                    mdl_delay = 10;
  int                    mdl_cnt = 0;
  logic                  mdl_vr = 1'b0;
  logic [3:0][3:0][15:0] mdl_c = '0;
  logic [3:0][3:0][15:0] mdl_prod = '0;
  logic                  spur_vr = 1'b0;

  assign i_validResult = mdl_vr | spur_vr;
  assign i_c = spur_vr ? {16{16'hDEAD}} : mdl_c;

  int vi_count = 0;
  int to_count = 0;
  int busy_rdy_viol = 0;

  function automatic logic [3:0][3:0][15:0] mm(input logic [3:0][3:0][7:0] a,
                                                input logic [3:0][3:0][7:0] b);
    logic [3:0][3:0][15:0] r;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        r[i][j] = 16'd0;
        for (int k = 0; k < 4; k++) r[i][j] = r[i][j] + 16'(a[i][k] * b[k][j]);
      end
    end
    return r;
  endfunction

  // Multiplier model: pulses the result mdl_delay cycles after the start strobe cycle.
  always @(negedge i_clk) begin
    mdl_vr = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt = mdl_cnt - 1;
      if (mdl_cnt == 0) begin
        mdl_vr = 1'b1;
        mdl_c  = mdl_prod;
      end
    end
    if (o_validInput && mdl_en) begin
      mdl_cnt  = mdl_delay;
      mdl_prod = mm(o_a, o_b);
    end
  end

  // Event monitor.
  always @(negedge i_clk) begin
    if (o_validInput) vi_count++;
    if (o_timeoutErr) to_count++;
    if (o_busy && o_inReady) busy_rdy_viol++;
  end

  task automatic send_byte(input logic [7:0] val);
    int w = 0;
    while (!o_inReady && w < 100) begin
      @(negedge i_clk);
      w++;
    end
    if (w >= 100) begin
      n_cmp++; n_bad++;
      $display("FAIL send_wait: o_inReady stuck at %b, required 1", o_inReady);
    end
    i_inData  = val;
    i_inValid = 1'b1;
    @(negedge i_clk);
    i_inValid = 1'b0;
  endtask

  // Streams A then B; leaves the bench on the first WAIT cycle.
  task automatic do_load(input logic [3:0][3:0][7:0] a, input logic [3:0][3:0][7:0] b,
                         input bit stall, input bit spur, input bit push);
    logic [3:0][3:0][15:0] e;
    logic [7:0] val;
    int vi0 = vi_count;
    for (int k = 0; k < 32; k++) begin
      val = (k < 16) ? a[k/4][k%4] : b[(k-16)/4][(k-16)%4];
      if (k == 31) begin
        n_cmp++;
        if (vi_count !== vi0 || o_inReady !== 1'b1) begin
          n_bad++;
          $display("FAIL early_start: starts=%0d ready=%b, required 0 and 1", vi_count - vi0,
                   o_inReady);
        end
      end
      send_byte(val);
      if (stall && (k == 7 || k == 20)) repeat (5) @(negedge i_clk);
      if (spur && k == 10) begin
        spur_vr = 1'b1;
        @(negedge i_clk);
        spur_vr = 1'b0;
      end
    end
    n_cmp++;
    if (o_validInput !== 1'b1 || o_inReady !== 1'b0 || o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL start_cycle: vi=%b rdy=%b busy=%b, required 1 0 1", o_validInput,
               o_inReady, o_busy);
    end
    n_cmp++;
    if (o_a !== a || o_b !== b) begin
      n_bad++;
      $display("FAIL load_mats: a=%h b=%h, required a=%h b=%h", o_a, o_b, a, b);
    end
    @(negedge i_clk);
    n_cmp++;
    if (o_validInput !== 1'b0) begin
      n_bad++;
      $display("FAIL start_len: o_validInput=%b after one cycle, required 0", o_validInput);
    end
    if (push) begin
      e = mm(a, b);
      for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) exp_q.push_back(e[r][c]);
    end
  endtask

  // mode 0: always ready; mode 1: ready pattern 1,0,0,... ; abort_at >= 0 returns early.
  task automatic drain(input int mode, input int abort_at, input bit spur);
    int hs = 0;
    int n = 0;
    bit stalled = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] exp;
    while (hs < 16 && n < 300) begin
      @(negedge i_clk);
      spur_vr = 1'b0;
      if (abort_at >= 0 && hs == abort_at) break;
      i_outReady = (mode == 0) ? 1'b1 : (n % 3 == 0);
      n++;
      if (stalled) begin
        stalled = 1'b0;
        n_cmp++;
        if (o_outData !== held) begin
          n_bad++;
          $display("FAIL stall_hold: o_outData=%h, required %h", o_outData, held);
        end
      end
      if (spur && hs == 7 && o_outValid) spur_vr = 1'b1;
      if (o_outValid) begin
        if (i_outReady) begin
          exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
          n_cmp++;
          if (o_outData !== exp) begin
            n_bad++;
            $display("FAIL word%0d: o_outData=%h, required %h", hs, o_outData, exp);
          end
          hs++;
        end else begin
          held    = o_outData;
          stalled = 1'b1;
        end
      end
    end
    spur_vr = 1'b0;
    if (abort_at < 0) begin
      if (hs < 16) begin
        n_cmp++; n_bad++;
        $display("FAIL drain_timeout: %0d words seen, required 16", hs);
      end
      @(negedge i_clk);
      i_outReady = 1'b0;
      n_cmp++;
      if (o_outValid !== 1'b0 || o_inReady !== 1'b1) begin
        n_bad++;
        $display("FAIL drain_end: valid=%b ready=%b, required 0 1", o_outValid, o_inReady);
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    n_cmp++;
    if (o_busy !== 1'b0 || o_validInput !== 1'b0 || o_outValid !== 1'b0 ||
        o_timeoutErr !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_ctl: busy=%b vi=%b ov=%b to=%b, required 0000", tag, o_busy,
               o_validInput, o_outValid, o_timeoutErr);
    end
    n_cmp++;
    if (o_a !== '0 || o_b !== '0 || o_outData !== 16'd0) begin
      n_bad++;
      $display("FAIL %s_data: a=%h b=%h out=%h, required zeros", tag, o_a, o_b, o_outData);
    end
  endtask

  task automatic test_reset();
    i_arst = 1'b1;
    repeat (2) @(negedge i_clk);
    check_reset_vals("reset_in");
    i_arst = 1'b0;
    @(negedge i_clk);
    check_reset_vals("reset_out");
    n_cmp++;
    if (o_inReady !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: o_inReady=%b, required 1", o_inReady);
    end
  endtask

  task automatic test_identity();
    logic [3:0][3:0][7:0] a, b;
    int to0 = to_count;
    for (int k = 0; k < 16; k++) begin
      a[k/4][k%4] = (k % 5 == 0) ? 8'd1 : 8'd0;
      b[k/4][k%4] = 8'(k + 1);
    end
    do_load(a, b, 1'b0, 1'b0, 1'b1);
    // Identity times B must give back 1..16 in order.
    for (int k = 0; k < 16; k++) begin
      n_cmp++;
      if (exp_q[k] !== 16'(k + 1)) begin
        n_bad++;
        $display("FAIL ident_model%0d: model=%h, required %h", k, exp_q[k], 16'(k + 1));
      end
    end
    drain(0, -1, 1'b0);
    n_cmp++;
    if (to_count !== to0) begin
      n_bad++;
      $display("FAIL ident_noerr: timeouts=%0d, required 0", to_count - to0);
    end
  endtask

  task automatic test_saturation();
    logic [3:0][3:0][7:0] a;
    a = {16{8'hFF}};
    do_load(a, a, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if (exp_q[0] !== 16'hF804) begin
      n_bad++;
      $display("FAIL sat_model: model=%h, required f804", exp_q[0]);
    end
    drain(1, -1, 1'b0);
  endtask

  task automatic test_input_stall();
    logic [3:0][3:0][7:0] a, b;
    for (int k = 0; k < 16; k++) begin
      a[k/4][k%4] = 8'($urandom_range(0, 255));
      b[k/4][k%4] = 8'($urandom_range(0, 255));
    end
    do_load(a, b, 1'b1, 1'b0, 1'b1);
    drain(0, -1, 1'b0);
    n_cmp++;
    if (busy_rdy_viol !== 0) begin
      n_bad++;
      $display("FAIL busy_ready: overlap cycles=%0d, required 0", busy_rdy_viol);
    end
  endtask

  task automatic test_timeout();
    logic [3:0][3:0][7:0] a, b;
    int k = 0;
    int to0 = to_count;
    bit saw_ov = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a[i/4][i%4] = 8'(i * 3);
      b[i/4][i%4] = 8'(100 - i);
    end
    mdl_en = 1'b0;
    do_load(a, b, 1'b0, 1'b0, 1'b0);
    while (!o_timeoutErr && k < 40) begin
      @(negedge i_clk);
      k++;
      if (o_outValid) saw_ov = 1'b1;
    end
    n_cmp++;
    if (k !== TO) begin
      n_bad++;
      $display("FAIL timeout_time: pulse %0d cycles after WAIT, required %0d", k, TO);
    end
    n_cmp++;
    if (saw_ov !== 1'b0 || o_inReady !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_state: outValid_seen=%b ready=%b, required 0 1", saw_ov, o_inReady);
    end
    @(negedge i_clk);
    n_cmp++;
    if (o_timeoutErr !== 1'b0 || to_count !== to0 + 1) begin
      n_bad++;
      $display("FAIL timeout_pulse: err=%b count=%0d, required 0 1", o_timeoutErr,
               to_count - to0);
    end
    mdl_en = 1'b1;
    do_load(b, a, 1'b0, 1'b0, 1'b1);
    drain(0, -1, 1'b0);
  endtask

  task automatic test_spurious();
    logic [3:0][3:0][7:0] a, b;
    int to0 = to_count;
    for (int i = 0; i < 16; i++) begin
      a[i/4][i%4] = 8'($urandom_range(0, 255));
      b[i/4][i%4] = 8'($urandom_range(0, 255));
    end
    do_load(a, b, 1'b0, 1'b1, 1'b1);
    drain(1, -1, 1'b1);
    // Result arriving on the timer-expiry cycle must still be taken.
    mdl_delay = TO;
    do_load(b, a, 1'b0, 1'b0, 1'b1);
    drain(0, -1, 1'b0);
    mdl_delay = 10;
    n_cmp++;
    if (to_count !== to0) begin
      n_bad++;
      $display("FAIL expiry_race: timeouts=%0d, required 0", to_count - to0);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0][3:0][7:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a[i/4][i%4] = 8'(i + 7);
      b[i/4][i%4] = 8'(200 - 3 * i);
    end
    do_load(a, b, 1'b0, 1'b0, 1'b1);
    drain(0, 5, 1'b0);
    i_arst = 1'b1;
    i_outReady = 1'b0;
    #1;
    check_reset_vals("mid_reset");
    @(negedge i_clk);
    i_arst = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    do_load(b, a, 1'b0, 1'b0, 1'b1);
    drain(0, -1, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_saturation();
    test_input_stall();
    test_timeout();
    test_spurious();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL leftover: %0d expected words unconsumed, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
